// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the seven-segment scan controller and its decoder.
package seven_seg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2
  } state_e;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Width of a digit index; never below one bit.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n <= 32'd1) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/seven_seg_scan_ctrl_dec.sv
// Combinational hex nibble to active-low seven-segment pattern {g,f,e,d,c,b,a}.
module seven_seg_scan_ctrl_dec (
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_c
);

  always_comb begin
    seg_c = 7'h7F;
    case (nibble_i)
      4'h0: seg_c = 7'h40;
      4'h1: seg_c = 7'h79;
      4'h2: seg_c = 7'h24;
      4'h3: seg_c = 7'h30;
      4'h4: seg_c = 7'h19;
      4'h5: seg_c = 7'h12;
      4'h6: seg_c = 7'h02;
      4'h7: seg_c = 7'h78;
      4'h8: seg_c = 7'h00;
      4'h9: seg_c = 7'h10;
      4'hA: seg_c = 7'h08;
      4'hB: seg_c = 7'h03;
      4'hC: seg_c = 7'h46;
      4'hD: seg_c = 7'h21;
      4'hE: seg_c = 7'h06;
      4'hF: seg_c = 7'h0E;
      default: seg_c = 7'h7F;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode seven-segment display.
// New values are double-buffered and only take effect at frame boundaries.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned DWELL      = 1000,
  parameter int unsigned BLANK      = 2,
  parameter int unsigned LZ_BLANK   = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      load_val,
  output logic                      load_rdy,
  input  logic [4*NUM_DIGITS-1:0]   load_data,
  output logic [NUM_DIGITS-1:0]     dig_en_n,
  output logic [6:0]                seg,
  output logic                      frame_done
);

  localparam int unsigned DW   = 4 * NUM_DIGITS;
  localparam int unsigned IW   = sel_width(NUM_DIGITS);
  localparam int unsigned CMAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int unsigned CW   = $clog2(CMAX + 1);

  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] DWELL_END = CW'(DWELL - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK - 1);

  state_e                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d, idx_nxt;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DW-1:0]         disp_q, disp_d;
  logic [DW-1:0]         pend_q, pend_d;
  logic                  pend_flag_q, pend_flag_d;
  logic [NUM_DIGITS-1:0] dig_en_n_q, dig_en_n_d;
  logic [6:0]            seg_q, seg_d;
  logic                  frame_done_q, frame_done_d;
  logic                  load_rdy_q, load_rdy_d;
  logic                  frame_end;
  logic                  commit;
  logic                  xfer;
  logic [NUM_DIGITS-1:0] lz_mask;
  logic [3:0]            nib_sel;
  logic [6:0]            dec_seg;

  // State register plus all registered datapath and outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      disp_q       <= '0;
      pend_q       <= '0;
      pend_flag_q  <= 1'b0;
      dig_en_n_q   <= '1;
      seg_q        <= SEG_OFF;
      frame_done_q <= 1'b0;
      load_rdy_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      disp_q       <= disp_d;
      pend_q       <= pend_d;
      pend_flag_q  <= pend_flag_d;
      dig_en_n_q   <= dig_en_n_d;
      seg_q        <= seg_d;
      frame_done_q <= frame_done_d;
      load_rdy_q   <= load_rdy_d;
    end
  end

  assign idx_nxt = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;

  // Next-state: dwell/blank timing and digit sequencing.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    frame_end = 1'b0;
    if (!en) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_SHOW;
          idx_d   = '0;
          cnt_d   = '0;
        end
        ST_SHOW: begin
          if (cnt_q == DWELL_END) begin
            cnt_d     = '0;
            frame_end = (idx_q == LAST_IDX);
            if (BLANK == 0) begin
              idx_d = idx_nxt;
            end else begin
              state_d = ST_BLANK;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_BLANK: begin
          if (cnt_q == BLANK_END) begin
            state_d = ST_SHOW;
            idx_d   = idx_nxt;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Double buffer: a pending value lands at a frame end, or at once when dark.
  always_comb begin
    commit      = pend_flag_q & (frame_end | (state_q == ST_IDLE) | ~en);
    xfer        = load_val & ~pend_flag_q;
    disp_d      = commit ? pend_q : disp_q;
    pend_d      = xfer ? load_data : pend_q;
    pend_flag_d = xfer | (pend_flag_q & ~commit);
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_lz
    assign lz_mask[g] = (LZ_BLANK != 0) && (g != 0) && (disp_d[DW-1:4*g] == '0);
  end

  assign nib_sel = disp_d[{idx_d, 2'b00} +: 4];

  seven_seg_scan_ctrl_dec u_dec (
    .nibble_i (nib_sel),
    .seg_c    (dec_seg)
  );

  // Output decode from the upcoming state so seg and digit enable move together.
  always_comb begin
    dig_en_n_d   = '1;
    seg_d        = SEG_OFF;
    frame_done_d = frame_end;
    load_rdy_d   = ~pend_flag_d;
    if (state_d == ST_SHOW && !lz_mask[idx_d]) begin
      dig_en_n_d[idx_d] = 1'b0;
      seg_d             = dec_seg;
    end
  end

  assign dig_en_n   = dig_en_n_q;
  assign seg        = seg_q;
  assign frame_done = frame_done_q;
  assign load_rdy   = load_rdy_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl with NUM_DIGITS=4, DWELL=4, BLANK=1, LZ_BLANK=1.
module tb_seven_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        load_val;
  logic        load_rdy;
  logic [15:0] load_data;
  logic [3:0]  dig_en_n;
  logic [6:0]  seg;
  logic        frame_done;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [15:0]     val;
    logic [3:0][6:0] segs;
    int              ld_cyc;
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS (4),
    .DWELL      (4),
    .BLANK      (1),
    .LZ_BLANK   (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .load_val   (load_val),
    .load_rdy   (load_rdy),
    .load_data  (load_data),
    .dig_en_n   (dig_en_n),
    .seg        (seg),
    .frame_done (frame_done)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One 20-cycle frame from the cycle before digit 0 lights; optional load at ld_cyc.
  task automatic check_frame(input string tag, input logic [3:0][6:0] segs, input int ld_cyc,
                             input logic [15:0] ld_a, input logic [15:0] ld_b, input logic hold);
    logic [1:0] d;
    int         k;
    logic [3:0] exp_en;
    logic [6:0] exp_seg;
    logic       exp_rdy;
    for (int c = 0; c < 20; c++) begin
      d = 2'(c / 5);
      k = c % 5;
      if (c == ld_cyc) begin
        load_val  = 1'b1;
        load_data = ld_a;
      end
      @(negedge clk);
      if (c == ld_cyc) begin
        if (hold) load_data = ld_b;
        else      load_val  = 1'b0;
      end
      if (k < 4 && segs[d] != 7'h7F) begin
        exp_en  = ~(4'(1) << d);
        exp_seg = segs[d];
      end else begin
        exp_en  = 4'hF;
        exp_seg = 7'h7F;
      end
      exp_rdy = (c == 19) || !(ld_cyc >= 0 && c >= ld_cyc);
      chk($sformatf("%s dig_en_n c%0d", tag, c), 16'(dig_en_n), 16'(exp_en));
      chk($sformatf("%s seg c%0d", tag, c), 16'(seg), 16'(exp_seg));
      chk($sformatf("%s frame_done c%0d", tag, c), 16'(frame_done), 16'(c == 19));
      chk($sformatf("%s load_rdy c%0d", tag, c), 16'(load_rdy), 16'(exp_rdy));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{16'h1234, {7'h79, 7'h24, 7'h30, 7'h19}, 6};
    vecs[1] = '{16'hABCD, {7'h08, 7'h03, 7'h46, 7'h21}, 2};
    vecs[2] = '{16'h0070, {7'h7F, 7'h7F, 7'h78, 7'h40}, 12};
    vecs[3] = '{16'h0000, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 17};
    vecs[4] = '{16'h5678, {7'h12, 7'h02, 7'h78, 7'h00}, 3};
    vecs[5] = '{16'h0809, {7'h7F, 7'h00, 7'h40, 7'h10}, 8};
    vecs[6] = '{16'h9EF0, {7'h10, 7'h06, 7'h0E, 7'h40}, -1};

    rst_n     = 1'b0;
    en        = 1'b0;
    load_val  = 1'b0;
    load_data = 16'h0;
    repeat (2) @(negedge clk);
    chk("reset dig_en_n", 16'(dig_en_n), 16'hF);
    chk("reset seg", 16'(seg), 16'h7F);
    chk("reset load_rdy", 16'(load_rdy), 16'h1);
    chk("reset frame_done", 16'(frame_done), 16'h0);
    rst_n = 1'b1;

    // Load while idle: accepted, then committed on the following cycle.
    @(negedge clk);
    load_val  = 1'b1;
    load_data = vecs[0].val;
    @(negedge clk);
    load_val = 1'b0;
    chk("idle load accepted", 16'(load_rdy), 16'h0);
    @(negedge clk);
    chk("idle commit rdy", 16'(load_rdy), 16'h1);
    chk("idle dark", 16'(dig_en_n), 16'hF);
    en = 1'b1;

    // Chained frames: each frame shows vecs[i] and loads vecs[i+1] part way through.
    for (int i = 0; i < 7; i++) begin
      if (i < 6)
        check_frame($sformatf("vec%0d", i), vecs[i].segs, vecs[i].ld_cyc, vecs[i+1].val, 16'h0, 1'b0);
      else
        check_frame($sformatf("vec%0d", i), vecs[i].segs, -1, 16'h0, 16'h0, 1'b0);
    end

    // load_val held high across two values: second waits for the first to commit.
    check_frame("b2b_a", vecs[6].segs, 0, vecs[0].val, vecs[4].val, 1'b1);
    check_frame("b2b_b", vecs[0].segs, 0, vecs[4].val, vecs[4].val, 1'b0);
    check_frame("b2b_c", vecs[4].segs, -1, 16'h0, 16'h0, 1'b0);

    // Disable during the blank after digit 2.
    repeat (15) @(negedge clk);
    chk("pre-disable blank", 16'(dig_en_n), 16'hF);
    en = 1'b0;
    @(negedge clk);
    chk("disable dig_en_n", 16'(dig_en_n), 16'hF);
    chk("disable seg", 16'(seg), 16'h7F);
    chk("disable frame_done", 16'(frame_done), 16'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("disabled fd %0d", i), 16'(frame_done), 16'h0);
      chk($sformatf("disabled dark %0d", i), 16'(dig_en_n), 16'hF);
    end
    en = 1'b1;
    check_frame("reenable", vecs[4].segs, -1, 16'h0, 16'h0, 1'b0);

    // Asynchronous reset mid-show with a value pending.
    load_val  = 1'b1;
    load_data = vecs[1].val;
    @(negedge clk);
    load_val = 1'b0;
    chk("pre-reset pending", 16'(load_rdy), 16'h0);
    repeat (6) @(negedge clk);
    chk("pre-reset lit d1", 16'(dig_en_n), 16'hD);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst dig_en_n", 16'(dig_en_n), 16'hF);
    chk("async rst seg", 16'(seg), 16'h7F);
    chk("async rst load_rdy", 16'(load_rdy), 16'h1);
    chk("async rst frame_done", 16'(frame_done), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    check_frame("post_rst0", vecs[3].segs, -1, 16'h0, 16'h0, 1'b0);
    check_frame("post_rst1", vecs[3].segs, -1, 16'h0, 16'h0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
